// File: rtl/munch_trail_gen.sv
// Munching-squares pixel generator with multi-frame phosphor trail.
// Frame-latched mode/palette/speed, frame divider and run/step control.
module munch_trail_gen #(
  parameter int CW         = 9,
  parameter int N_LAG      = 15,
  parameter int HOT_END    = 2,
  parameter int MID_END    = 6,
  parameter int WIN_W      = 512,
  parameter int WIN_H      = 480,
  parameter int SPEED_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            hpos,
  input  logic [9:0]            vpos,
  input  logic                  vsync,
  input  logic [1:0]            mode_in,
  input  logic [SPEED_BITS-1:0] speed_in,
  input  logic                  palette_in,
  input  logic                  run,
  input  logic                  step,
  output logic [1:0]            R,
  output logic [1:0]            G,
  output logic [1:0]            B,
  output logic [CW-1:0]         frame_no,
  output logic                  frame_tick
);

  typedef enum logic [1:0] {
    M_XOR  = 2'd0,
    M_ADD  = 2'd1,
    M_XNOR = 2'd2,
    M_SUB  = 2'd3
  } mode_e;

  localparam logic [10:0] LP_WW = 11'(WIN_W);
  localparam logic [10:0] LP_WH = 11'(WIN_H);
  localparam logic [5:0]  LP_HOT = 6'(HOT_END);
  localparam logic [5:0]  LP_MID = 6'(MID_END);
  localparam logic [CW-1:0] LP_ONE_F = 1;
  localparam logic [SPEED_BITS-1:0] LP_ONE_S = 1;

  mode_e                 r_mode;
  logic [SPEED_BITS-1:0] r_speed;
  logic                  r_pal;
  logic [SPEED_BITS-1:0] r_div;
  logic                  r_pend;
  logic                  r_prev_vs;
  logic [CW-1:0]         r_frame;
  logic                  r_tick;
  logic [1:0]            r_r;
  logic [1:0]            r_g;
  logic [1:0]            r_b;

  logic                  w_edge;
  logic                  w_div_hit;
  logic                  w_adv;
  logic [CW-1:0]         w_x;
  logic [CW-1:0]         w_y;
  logic [N_LAG-1:0]      w_hit;
  logic                  w_any;
  logic [5:0]            w_win;
  logic                  w_head;
  logic                  w_yel;
  logic                  w_vis;
  logic                  w_on;
  logic [1:0]            w_lvl;
  logic [1:0]            w_r;
  logic [1:0]            w_g;
  logic [1:0]            w_b;

  assign w_edge    = vsync & ~r_prev_vs;
  assign w_div_hit = (r_div == r_speed);
  assign w_adv     = w_edge & (run ? w_div_hit : r_pend);

  assign w_x = hpos[CW-1:0];
  assign w_y = vpos[CW-1:0];

  // One comparator per lag; all evaluated in parallel against this pixel.
  for (genvar gi = 0; gi < N_LAG; gi++) begin : g_lag
    logic [CW-1:0] w_t;
    logic [CW-1:0] w_f;
    assign w_t = r_frame - CW'(gi);
    always_comb begin
      w_f = w_y ^ w_t;
      case (r_mode)
        M_XOR:  w_f = w_y ^ w_t;
        M_ADD:  w_f = w_y + w_t;
        M_XNOR: w_f = ~(w_y ^ w_t);
        M_SUB:  w_f = w_t - w_y;
        default: w_f = w_y ^ w_t;
      endcase
    end
    assign w_hit[gi] = (w_x == w_f);
  end

  // Scan from the oldest lag down so the nearest hit overrides.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = N_LAG - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any = 1'b1;
        w_win = 6'(i);
      end
    end
  end

  assign w_head = (w_win == 6'd0);
  assign w_yel  = ~(w_head ^ r_pal);
  assign w_vis  = ({1'b0, hpos} < LP_WW) & ({1'b0, vpos} < LP_WH);
  assign w_on   = w_any & w_vis;

  always_comb begin
    w_lvl = 2'd1;
    if (w_win <= LP_HOT)
      w_lvl = 2'd3;
    else if (w_win <= LP_MID)
      w_lvl = 2'd2;
  end

  assign w_r = (w_on & w_yel)  ? w_lvl : 2'd0;
  assign w_g = w_on            ? w_lvl : 2'd0;
  assign w_b = (w_on & ~w_yel) ? w_lvl : 2'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode    <= M_XOR;
      r_speed   <= '0;
      r_pal     <= 1'b0;
      r_div     <= '0;
      r_pend    <= 1'b0;
      r_prev_vs <= 1'b1;
      r_frame   <= '0;
      r_tick    <= 1'b0;
      r_r       <= 2'd0;
      r_g       <= 2'd0;
      r_b       <= 2'd0;
    end else begin
      r_prev_vs <= vsync;
      r_tick    <= w_edge;
      r_r       <= w_r;
      r_g       <= w_g;
      r_b       <= w_b;
      if (w_edge) begin
        r_mode  <= mode_e'(mode_in);
        r_speed <= speed_in;
        r_pal   <= palette_in;
        if (run)
          r_div <= w_div_hit ? '0 : r_div + LP_ONE_S;
      end
      if (w_adv)
        r_frame <= r_frame + LP_ONE_F;
      // A step coinciding with an edge stays pending for the next edge.
      if (w_edge & run)
        r_pend <= 1'b0;
      else if (step & ~run)
        r_pend <= 1'b1;
      else if (w_adv)
        r_pend <= 1'b0;
    end
  end

  assign R          = r_r;
  assign G          = r_g;
  assign B          = r_b;
  assign frame_no   = r_frame;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_munch_trail_gen.sv
// Bench for munch_trail_gen: directed vectors, corner sequences and
// randomized traffic checked against a frame-level reference model.
module tb_munch_trail_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       vsync;
  logic [1:0] mode_in;
  logic [3:0] speed_in;
  logic       palette_in;
  logic       run;
  logic       step;
  logic [1:0] R, G, B;
  logic [8:0] frame_no;
  logic       frame_tick;

  munch_trail_gen dut (
    .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .vsync(vsync),
    .mode_in(mode_in), .speed_in(speed_in), .palette_in(palette_in),
    .run(run), .step(step), .R(R), .G(G), .B(B),
    .frame_no(frame_no), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  int m_frame, m_div, m_pend, m_mode, m_speed, m_pal, m_prev;

  typedef struct {
    int h;
    int v;
    int e;
  } vec_t;
  vec_t vt[14];

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  function automatic int ref_f(int md, int v, int t);
    case (md)
      0: return v ^ t;
      1: return (v + t) % 512;
      2: return (~(v ^ t)) & 511;
      default: return ((t - v) % 512 + 512) % 512;
    endcase
  endfunction

  // Packed colour R*16+G*4+B expected for a pixel.
  function automatic int ref_rgb(int h, int v, int fn, int md, int pal);
    int t, lvl;
    bit yel;
    if (h >= 512 || v >= 480) return 0;
    for (int i = 0; i < 15; i++) begin
      t = ((fn - i) % 512 + 512) % 512;
      if ((h % 512) == ref_f(md, v % 512, t)) begin
        lvl = (i <= 2) ? 3 : (i <= 6) ? 2 : 1;
        yel = (i == 0) ? (pal == 1) : (pal == 0);
        return yel ? (lvl * 16 + lvl * 4) : (lvl * 4 + lvl);
      end
    end
    return 0;
  endfunction

  function automatic int dut_rgb();
    return int'({R, G, B});
  endfunction

  task automatic model_reset();
    m_frame = 0; m_div = 0; m_pend = 0;
    m_mode = 0; m_speed = 0; m_pal = 0; m_prev = 1;
  endtask

  task automatic cyc();
    int exp;
    bit edg, adv;
    edg = (vsync == 1'b1) && (m_prev == 0);
    exp = ref_rgb(int'(hpos), int'(vpos), m_frame, m_mode, m_pal);
    adv = 0;
    if (edg) begin
      if (run) begin
        if (m_div == m_speed) begin adv = 1; m_div = 0; end
        else m_div = (m_div + 1) % 16;
        m_pend = 0;
      end else if (m_pend != 0) begin
        adv = 1; m_pend = 0;
      end
      m_mode = int'(mode_in);
      m_speed = int'(speed_in);
      m_pal = int'(palette_in);
      if (adv) m_frame = (m_frame + 1) % 512;
    end
    if (!run && step) m_pend = 1;
    m_prev = int'(vsync);
    @(posedge clk); #1;
    chk("rgb", dut_rgb(), exp);
    chk("frame_no", int'(frame_no), m_frame);
    chk("frame_tick", int'(frame_tick), int'(edg));
  endtask

  task automatic vedge();
    vsync = 1'b0; cyc();
    vsync = 1'b1; cyc();
  endtask

  task automatic do_reset(bit chk_now);
    rst = 1'b1;
    #1;
    if (chk_now) begin
      chk("async_rst_rgb", dut_rgb(), 0);
      chk("async_rst_frame", int'(frame_no), 0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", dut_rgb(), 0);
    chk("rst_tick", int'(frame_tick), 0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int k, t;
    vt[0]  = '{3, 0, 15};
    vt[1]  = '{2, 0, 60};
    vt[2]  = '{1, 0, 60};
    vt[3]  = '{0, 0, 40};
    vt[4]  = '{511, 0, 40};
    vt[5]  = '{509, 0, 40};
    vt[6]  = '{508, 0, 20};
    vt[7]  = '{505, 0, 20};
    vt[8]  = '{501, 0, 20};
    vt[9]  = '{500, 0, 0};
    vt[10] = '{7, 0, 0};
    vt[11] = '{515, 0, 0};
    vt[12] = '{476, 479, 15};
    vt[13] = '{483, 480, 0};

    hpos = 10'd1023; vpos = 10'd1023; vsync = 1'b1;
    mode_in = 2'd0; speed_in = 4'd0; palette_in = 1'b0;
    run = 1'b1; step = 1'b0;
    do_reset(1'b0);

    repeat (100) cyc();
    chk("reset_frame", int'(frame_no), 0);

    speed_in = 4'd2;
    repeat (9) vedge();
    chk("div_frame", int'(frame_no), 3);

    for (int i = 0; i < 14; i++) begin
      hpos = 10'(vt[i].h);
      vpos = 10'(vt[i].v);
      cyc();
      chk($sformatf("vec%0d", i), dut_rgb(), vt[i].e);
    end

    hpos = 10'd1023; vpos = 10'd1023;
    speed_in = 4'd0;
    repeat (508) vedge();
    chk("pre_wrap", int'(frame_no), 511);
    vedge();
    chk("wrap", int'(frame_no), 0);

    hpos = 10'd512; vpos = 10'd0; cyc();
    chk("clip", dut_rgb(), 0);
    hpos = 10'd0; cyc();
    chk("head_f0", dut_rgb(), 15);

    run = 1'b0;
    repeat (3) vedge();
    chk("pause", int'(frame_no), 0);
    step = 1'b1; cyc(); step = 1'b0; cyc();
    step = 1'b1; cyc(); step = 1'b0; cyc();
    vedge();
    chk("step_once", int'(frame_no), 1);
    vedge();
    chk("step_coalesce", int'(frame_no), 1);
    vsync = 1'b0; cyc();
    vsync = 1'b1; step = 1'b1; cyc(); step = 1'b0;
    chk("step_at_edge", int'(frame_no), 1);
    vedge();
    chk("step_next_edge", int'(frame_no), 2);

    hpos = 10'd0; vpos = 10'd0; cyc();
    do_reset(1'b1);

    mode_in = 2'd1; palette_in = 1'b1;
    hpos = 10'd7; vpos = 10'd7;
    cyc();
    chk("latch_pre", dut_rgb(), 15);
    vedge();
    cyc();
    chk("latch_post", dut_rgb(), 60);

    run = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) vsync = ~vsync;
      if ($urandom_range(0, 63) == 0) run = ~run;
      step = ($urandom_range(0, 15) == 0);
      mode_in = 2'($urandom_range(0, 3));
      speed_in = 4'($urandom_range(0, 3));
      palette_in = 1'($urandom_range(0, 1));
      vpos = 10'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 0) begin
        k = $urandom_range(0, 16);
        t = ((m_frame - k) % 512 + 512) % 512;
        hpos = 10'(ref_f(m_mode, int'(vpos), t)
               + ($urandom_range(0, 7) == 0 ? 512 : 0));
      end else begin
        hpos = 10'($urandom_range(0, 1023));
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
